// File: rtl/tuple_pair_scan_ctrl.sv
// Pair-sum scanner: walks every index pair (i<j) of the first n ROM words and streams
// out, over valid/ready, each pair whose signed sum equals a target latched at start.
module tuple_pair_scan_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W:0]          n_elems,
  input  logic signed [DATA_W-1:0] target,
  output logic                     rom_cs,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic signed [DATA_W-1:0] rom_dout,
  output logic                     match_valid,
  input  logic                     match_ready,
  output logic [ADDR_W-1:0]        match_i,
  output logic [ADDR_W-1:0]        match_j,
  output logic [CNT_W-1:0]         match_count,
  output logic                     busy,
  output logic                     done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_SCAN   = 3'd2;
  localparam logic [2:0] S_EMIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

  function automatic logic [ADDR_W:0] f_clamp_n(input logic [ADDR_W:0] n);
    return (n > DEPTH) ? DEPTH : n;
  endfunction

  // One guard bit keeps the sum exact, so -128 + -128 cannot alias onto 0.
  function automatic logic f_sum_hit(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b,
                                     input logic signed [DATA_W-1:0] t);
    logic signed [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    return sum == {t[DATA_W-1], t};
  endfunction

  logic [2:0]               r_state;
  logic [ADDR_W-1:0]        r_last;
  logic signed [DATA_W-1:0] r_target;
  logic signed [DATA_W-1:0] r_a;
  logic [ADDR_W-1:0]        r_i;
  logic [ADDR_W-1:0]        r_j;
  logic [ADDR_W-1:0]        r_match_i;
  logic [ADDR_W-1:0]        r_match_j;
  logic [CNT_W-1:0]         r_count;

  logic [ADDR_W:0]          w_n;
  logic                     w_j_end;
  logic                     w_i_end;
  logic                     w_hit;
  logic [2:0]               w_adv_state;
  logic [ADDR_W-1:0]        w_adv_i;
  logic [ADDR_W-1:0]        w_adv_j;

  assign w_n     = f_clamp_n(n_elems);
  assign w_j_end = (r_j == r_last);
  assign w_i_end = (r_i == r_last - ADDR_W'(1));
  assign w_hit   = f_sum_hit(r_a, rom_dout, r_target);

  // Shared step to the next pair, used after a miss in SCAN and after a handshake in EMIT.
  always_comb begin
    w_adv_state = S_SCAN;
    w_adv_i     = r_i;
    w_adv_j     = r_j + ADDR_W'(1);
    if (w_j_end && w_i_end) begin
      w_adv_state = S_DONE;
      w_adv_j     = r_j;
    end else if (w_j_end) begin
      w_adv_state = S_LOAD_A;
      w_adv_i     = r_i + ADDR_W'(1);
      w_adv_j     = r_j;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_last    <= '0;
      r_target  <= '0;
      r_a       <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_match_i <= '0;
      r_match_j <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_target <= target;
            r_count  <= '0;
            r_last   <= ADDR_W'(w_n - (ADDR_W+1)'(1));
            if (w_n >= (ADDR_W+1)'(2)) begin
              r_i     <= '0;
              r_state <= S_LOAD_A;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_LOAD_A: begin
          r_a     <= rom_dout;
          r_j     <= r_i + ADDR_W'(1);
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          if (w_hit) begin
            r_match_i <= r_i;
            r_match_j <= r_j;
            r_state   <= S_EMIT;
          end else begin
            r_i     <= w_adv_i;
            r_j     <= w_adv_j;
            r_state <= w_adv_state;
          end
        end
        S_EMIT: begin
          if (match_ready) begin
            r_count <= r_count + CNT_W'(1);
            r_i     <= w_adv_i;
            r_j     <= w_adv_j;
            r_state <= w_adv_state;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ROM port is driven only while a word is actually being read.
  always_comb begin
    rom_cs   = 1'b0;
    rom_addr = '0;
    case (r_state)
      S_LOAD_A: begin
        rom_cs   = 1'b1;
        rom_addr = r_i;
      end
      S_SCAN: begin
        rom_cs   = 1'b1;
        rom_addr = r_j;
      end
      default: begin
        rom_cs   = 1'b0;
        rom_addr = '0;
      end
    endcase
  end

  assign match_valid = (r_state == S_EMIT);
  assign match_i     = r_match_i;
  assign match_j     = r_match_j;
  assign match_count = r_count;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_tuple_pair_scan_ctrl.sv
// Directed bench for tuple_pair_scan_ctrl: behavioural ROM, scenario tasks with
// hand-computed pair lists, counts and done latencies.
module tb_tuple_pair_scan_ctrl;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [8:0]        n_elems;
  logic signed [7:0] target;
  logic              rom_cs;
  logic [7:0]        rom_addr;
  logic signed [7:0] rom_dout;
  logic              match_valid;
  logic              match_ready;
  logic [7:0]        match_i;
  logic [7:0]        match_j;
  logic [15:0]       match_count;
  logic              busy;
  logic              done;

  logic signed [7:0] mem [256];

  int vectors = 0;
  int miscompares = 0;

  int got_i[$];
  int got_j[$];
  int latency;
  int final_count;
  bit timed_out, saw_cs, emit_cs_bad, stall_bad, busy_at_done, done_after, busy_after;

  tuple_pair_scan_ctrl #(.ADDR_W(8), .DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_elems(n_elems), .target(target),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .match_valid(match_valid), .match_ready(match_ready),
    .match_i(match_i), .match_j(match_j), .match_count(match_count),
    .busy(busy), .done(done)
  );

  assign rom_dout = rom_cs ? mem[rom_addr] : 8'sd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Runs one scan; latency k means done is high at the k-th rising edge after the start edge.
  task automatic run_scan(input int n, input int tgt, input int stall, input int poke);
    int stall_left;
    bit in_stall;
    logic [7:0] hold_i, hold_j;
    got_i.delete();
    got_j.delete();
    latency = 0; final_count = -1; timed_out = 1'b1; saw_cs = 1'b0;
    emit_cs_bad = 1'b0; stall_bad = 1'b0; busy_at_done = 1'b0;
    stall_left = stall; in_stall = 1'b0; hold_i = '0; hold_j = '0;
    @(negedge clk);
    n_elems = 9'(n); target = 8'(tgt); start = 1'b1; match_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; n_elems = 9'd0; target = 8'sd7;
    for (int k = 1; k <= 40000; k++) begin
      @(negedge clk);
      start = (k == poke);
      if (match_valid && stall_left > 0) begin
        if (!in_stall) begin
          hold_i = match_i; hold_j = match_j;
        end else if (match_i !== hold_i || match_j !== hold_j) begin
          stall_bad = 1'b1;
        end
        in_stall = 1'b1; stall_left--; match_ready = 1'b0;
      end else begin
        if (in_stall && (!match_valid || match_i !== hold_i || match_j !== hold_j))
          stall_bad = 1'b1;
        match_ready = 1'b1;
      end
      if (match_valid && match_ready) begin
        got_i.push_back(int'(match_i));
        got_j.push_back(int'(match_j));
        in_stall = 1'b0;
      end
      if (rom_cs) saw_cs = 1'b1;
      if (match_valid && rom_cs) emit_cs_bad = 1'b1;
      if (done) begin
        latency = k; timed_out = 1'b0;
        final_count = int'(match_count); busy_at_done = busy;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0; match_ready = 1'b1;
    done_after = done; busy_after = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; n_elems = '0; target = '0; match_ready = 1'b1;
    #3;
    vectors++;
    if ({rom_cs, rom_addr, match_valid, match_i, match_j, match_count, busy, done} !== 44'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h required 0",
               {rom_cs, rom_addr, match_valid, match_i, match_j, match_count, busy, done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_target_zero();
    int ei[3] = '{0, 1, 2};
    int ej[3] = '{3, 6, 4};
    run_scan(8, 0, 0, 0);
    vectors++;
    if (timed_out || latency !== 39) begin
      miscompares++; $display("FAIL t0_latency: got %0d (timeout %b) required 39", latency, timed_out);
    end
    vectors++;
    if (got_i.size() !== 3) begin
      miscompares++; $display("FAIL t0_npairs: got %0d required 3", got_i.size());
    end else begin
      for (int p = 0; p < 3; p++) begin
        vectors++;
        if (got_i[p] !== ei[p] || got_j[p] !== ej[p]) begin
          miscompares++;
          $display("FAIL t0_pair%0d: got (%0d,%0d) required (%0d,%0d)", p, got_i[p], got_j[p], ei[p], ej[p]);
        end
      end
    end
    vectors++;
    if (final_count !== 3) begin
      miscompares++; $display("FAIL t0_count: got %0d required 3", final_count);
    end
    vectors++;
    if (busy_at_done !== 1'b1 || done_after !== 1'b0 || busy_after !== 1'b0) begin
      miscompares++;
      $display("FAIL t0_done_pulse: busy_at_done=%b done_next=%b busy_next=%b required 1 0 0",
               busy_at_done, done_after, busy_after);
    end
    vectors++;
    if (emit_cs_bad !== 1'b0) begin
      miscompares++; $display("FAIL t0_emit_cs: rom_cs=1 while match_valid, required 0");
    end
    vectors++;
    if (match_count !== 16'd3) begin
      miscompares++; $display("FAIL t0_count_hold: got %0d required 3", match_count);
    end
  endtask

  task automatic test_other_targets();
    int ei[3] = '{1, 4, 6};
    int ej[3] = '{3, 5, 7};
    run_scan(8, 3, 0, 0);
    vectors++;
    if (timed_out || latency !== 39 || final_count !== 3) begin
      miscompares++;
      $display("FAIL t3_summary: latency %0d count %0d required 39 3", latency, final_count);
    end
    vectors++;
    if (got_i.size() !== 3) begin
      miscompares++; $display("FAIL t3_npairs: got %0d required 3", got_i.size());
    end else begin
      for (int p = 0; p < 3; p++) begin
        vectors++;
        if (got_i[p] !== ei[p] || got_j[p] !== ej[p]) begin
          miscompares++;
          $display("FAIL t3_pair%0d: got (%0d,%0d) required (%0d,%0d)", p, got_i[p], got_j[p], ei[p], ej[p]);
        end
      end
    end
    run_scan(8, -8, 0, 0);
    vectors++;
    if (timed_out || latency !== 37 || final_count !== 1) begin
      miscompares++;
      $display("FAIL tm8_summary: latency %0d count %0d required 37 1", latency, final_count);
    end
    vectors++;
    if (got_i.size() !== 1 || got_i[0] !== 0 || got_j[0] !== 2) begin
      miscompares++;
      $display("FAIL tm8_pair: got %0d pairs, first (%0d,%0d) required 1 pair (0,2)",
               got_i.size(), (got_i.size() > 0) ? got_i[0] : -1, (got_j.size() > 0) ? got_j[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    run_scan(8, 0, 5, 0);
    vectors++;
    if (timed_out || latency !== 44) begin
      miscompares++; $display("FAIL stall_latency: got %0d required 44", latency);
    end
    vectors++;
    if (stall_bad !== 1'b0) begin
      miscompares++; $display("FAIL stall_hold: pair or valid changed during stall, required stable");
    end
    vectors++;
    if (emit_cs_bad !== 1'b0) begin
      miscompares++; $display("FAIL stall_cs: rom_cs=1 during stall, required 0");
    end
    vectors++;
    if (final_count !== 3 || got_i.size() !== 3 || got_i[0] !== 0 || got_j[0] !== 3) begin
      miscompares++;
      $display("FAIL stall_result: count %0d pairs %0d required 3 3 first (0,3)", final_count, got_i.size());
    end
  endtask

  task automatic test_no_wrap();
    mem[0] = -8'sd128; mem[1] = -8'sd128;
    run_scan(2, 0, 0, 0);
    vectors++;
    if (timed_out || latency !== 3 || final_count !== 0 || got_i.size() !== 0) begin
      miscompares++;
      $display("FAIL wrap_t0: latency %0d count %0d pairs %0d required 3 0 0", latency, final_count, got_i.size());
    end
    run_scan(2, -128, 0, 0);
    vectors++;
    if (timed_out || latency !== 3 || final_count !== 0 || got_i.size() !== 0) begin
      miscompares++;
      $display("FAIL wrap_tm128: latency %0d count %0d pairs %0d required 3 0 0", latency, final_count, got_i.size());
    end
    mem[1] = 8'sd0;
    run_scan(2, -128, 0, 0);
    vectors++;
    if (timed_out || latency !== 4 || final_count !== 1 || got_i.size() !== 1) begin
      miscompares++;
      $display("FAIL edge_pair: latency %0d count %0d pairs %0d required 4 1 1", latency, final_count, got_i.size());
    end else begin
      vectors++;
      if (got_i[0] !== 0 || got_j[0] !== 1) begin
        miscompares++; $display("FAIL edge_pair_idx: got (%0d,%0d) required (0,1)", got_i[0], got_j[0]);
      end
    end
    mem[0] = -8'sd5; mem[1] = -8'sd2;
  endtask

  task automatic test_small_n();
    for (int n = 1; n >= 0; n--) begin
      run_scan(n, 0, 0, 0);
      vectors++;
      if (timed_out || latency !== 1 || final_count !== 0) begin
        miscompares++;
        $display("FAIL small_n%0d: latency %0d count %0d required 1 0", n, latency, final_count);
      end
      vectors++;
      if (saw_cs !== 1'b0 || got_i.size() !== 0) begin
        miscompares++;
        $display("FAIL small_n%0d_access: rom_cs seen %b pairs %0d required 0 0", n, saw_cs, got_i.size());
      end
    end
  endtask

  task automatic test_start_while_busy();
    run_scan(8, 0, 0, 10);
    vectors++;
    if (timed_out || latency !== 39 || final_count !== 3 || got_i.size() !== 3) begin
      miscompares++;
      $display("FAIL busy_start: latency %0d count %0d pairs %0d required 39 3 3", latency, final_count, got_i.size());
    end
    vectors++;
    if (busy_after !== 1'b0) begin
      miscompares++; $display("FAIL busy_start_idle: busy %b required 0", busy_after);
    end
  endtask

  task automatic test_clamp_full_depth();
    run_scan(300, 0, 0, 0);
    vectors++;
    if (timed_out || latency !== 32899) begin
      miscompares++; $display("FAIL clamp_latency: got %0d required 32899", latency);
    end
    vectors++;
    if (final_count !== 3 || got_i.size() !== 3) begin
      miscompares++; $display("FAIL clamp_count: got %0d required 3", final_count);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    n_elems = 9'd8; target = 8'sd0; start = 1'b1; match_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (rom_cs !== 1'b1 || rom_addr !== 8'd4 || match_count !== 16'd1 || match_j !== 8'd3) begin
      miscompares++;
      $display("FAIL pre_reset: cs %b addr %0d count %0d j %0d required 1 4 1 3", rom_cs, rom_addr, match_count, match_j);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({rom_cs, rom_addr, match_valid, match_i, match_j, match_count, busy, done} !== 44'd0) begin
      miscompares++;
      $display("FAIL async_reset: got %h required 0",
               {rom_cs, rom_addr, match_valid, match_i, match_j, match_count, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(8, 0, 0, 0);
    vectors++;
    if (timed_out || latency !== 39 || final_count !== 3 || got_i.size() !== 3) begin
      miscompares++;
      $display("FAIL post_reset: latency %0d count %0d pairs %0d required 39 3 3", latency, final_count, got_i.size());
    end else begin
      vectors++;
      if (got_i[2] !== 2 || got_j[2] !== 4) begin
        miscompares++; $display("FAIL post_reset_pair: got (%0d,%0d) required (2,4)", got_i[2], got_j[2]);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'sd100;
    mem[0] = -8'sd5; mem[1] = -8'sd2; mem[2] = -8'sd3; mem[3] = 8'sd5;
    mem[4] = 8'sd3;  mem[5] = 8'sd0;  mem[6] = 8'sd2;  mem[7] = 8'sd1;
    test_reset();
    test_target_zero();
    test_other_targets();
    test_backpressure();
    test_no_wrap();
    test_small_n();
    test_start_while_busy();
    test_clamp_full_depth();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tuple_pair_scan_ctrl.md
Name: tuple_pair_scan_ctrl

Overview:
- Sequences the 256x8 signed constant ROM to find every index pair (i<j) among the first N entries whose signed sum equals a programmed target.
- Sole owner of the ROM's single combinational read port (cs/addr/dout).
- Streams each matching pair out over a valid/ready handshake and reports a running match count plus a one-cycle completion pulse.

Parameters:
- ADDR_W, 8, ROM address width; depth is 2**ADDR_W.
- DATA_W, 8, ROM word width; two's-complement signed.
- CNT_W, 16, width of match_count; must hold (2**ADDR_W choose 2).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a scan; sampled only in IDLE.
- n_elems  input  ADDR_W+1  number of ROM entries to scan (0..256); latched at start; values >256 are clamped to 256.
- target  input  DATA_W  signed target sum; latched at start.
- rom_cs  output  1  ROM chip select.
- rom_addr  output  ADDR_W  ROM address.
- rom_dout  input  DATA_W  ROM read data; combinational, valid in the same cycle.
- match_valid  output  1  a pair is presented.
- match_ready  input  1  consumer accepts the pair.
- match_i  output  ADDR_W  lower index of the pair.
- match_j  output  ADDR_W  upper index of the pair.
- match_count  output  CNT_W  number of accepted matches in the current or last scan.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a scan finishes.

Behaviour:
- Reset: asynchronous reset drives the FSM to IDLE and clears all outputs and registers (rom_cs=0, rom_addr=0, match_valid=0, match_i=0, match_j=0, match_count=0, busy=0, done=0). This applies mid-scan as well; a pending match is dropped.
- States: IDLE, LOAD_A, SCAN, EMIT, DONE.
- IDLE:
  - On start, latch n_elems (clamped) and target, and clear match_count.
  - If n>=2, set i=0 and go to LOAD_A; otherwise go straight to DONE.
  - start is ignored in all other states.
- LOAD_A: rom_cs=1, rom_addr=i. Capture rom_dout into a_reg, set j=i+1, go to SCAN.
- SCAN:
  - rom_cs=1, rom_addr=j.
  - Compute sum = sext(a_reg)+sext(rom_dout) at DATA_W+1 bits and compare with sext(target). The comparison must not wrap: -128 + -128 never matches target 0.
  - On a match, register match_i=i and match_j=j, then go to EMIT.
  - Otherwise ADVANCE.
- EMIT:
  - rom_cs=0; match_valid=1, with match_i and match_j held stable until the handshake.
  - On match_valid && match_ready: match_count += 1, deassert match_valid next cycle, then ADVANCE.
- ADVANCE (transition rule, not a state):
  - If j==n-1 and i==n-2, go to DONE.
  - Else if j==n-1, i+=1 and go to LOAD_A.
  - Else j+=1 and stay in SCAN.
- DONE: done=1 for exactly one cycle, busy still 1; next state is IDLE. match_count holds its value until the next accepted start.
- rom_cs is 0 and rom_addr is 0 in IDLE, EMIT and DONE.
- Latency: with no matches, done asserts on the (n-1) + n(n-1)/2 + 1 th rising edge after the edge that samples start. Each match adds 1 cycle plus any match_ready stall cycles.
- Boundaries:
  - n=0 or n=1: done on the 1st edge after start; count 0; match_valid never asserts; rom_cs never asserts.
  - n=256: i reaches 254 and j reaches 255 with no address wrap.
  - match_count never overflows with the default CNT_W.

Test Plan:
- ROM entries 0..7 = {-5,-2,-3,5,3,0,2,1}, n=8, target=0, match_ready=1 -> pairs (0,3),(1,6),(2,4) in that order; match_count=3; done on edge 36+3=39 after start.
- Same ROM, n=8, target=3 -> pairs (1,3),(4,5),(6,7); count=3. With target=-8 -> single pair (0,2); count=1.
- Same ROM, target=0, match_ready held low for 5 cycles on the first match -> match_valid, match_i=0 and match_j=3 stay stable through the stall; rom_cs=0 during the stall; total latency +5; count still 3.
- Behavioural ROM with entries 0,1 = -128,-128; n=2, target=0 -> no match (no wrap). Same data with target=-128 -> no match; with entry1 = 0, target=-128 -> pair (0,1).
- n=1 and n=0 -> done pulse 1 edge after start, count=0, no ROM access. start pulsed while busy -> ignored; the scan completes with unchanged results.
- rst_n asserted during SCAN of the n=8 target=0 run -> all outputs 0 immediately (asynchronously). A fresh start after release reproduces the full 3-pair result.
